// File: rtl/udp_tx_noc_out.sv
// UDP TX payload to noc0: header flit, IP TX metadata flit, then data flits.
// Optional UDP_TX_NOC_OUT_ZERO_PAD_EN zeroes pad bytes of the last data flit.
package udp_tx_noc_out_pkg;
  localparam int IP_ADDR_W = 32;
  localparam int TOT_LEN_W = 16;
  localparam int MSG_LENGTH_WIDTH = 22;
  localparam int MSG_TYPE_W = 8;
  localparam int XY_W = 8;
  localparam int CHIP_ID_W = 14;
  localparam int FBITS_W = 4;
  localparam int MAC_PADBYTES_W = 6;
  localparam int PKT_NUM_W = 16;
  localparam int TIMESTAMP_W = 64;

  localparam logic [MSG_TYPE_W-1:0] IP_TX_MSG_TYPE = 8'd3;

  typedef struct packed {
    logic [PKT_NUM_W-1:0]   packet_id;
    logic [TIMESTAMP_W-1:0] timestamp;
  } tracker_stats_struct;

  typedef struct packed {
    logic [CHIP_ID_W-1:0]        dst_chip_id;
    logic [XY_W-1:0]             dst_x;
    logic [XY_W-1:0]             dst_y;
    logic [FBITS_W-1:0]          dst_fbits;
    logic [MSG_LENGTH_WIDTH-1:0] msg_len;
    logic [MSG_TYPE_W-1:0]       msg_type;
    logic [CHIP_ID_W-1:0]        src_chip_id;
    logic [XY_W-1:0]             src_x;
    logic [XY_W-1:0]             src_y;
    logic [FBITS_W-1:0]          src_fbits;
  } noc_route_t;

  typedef struct packed {
    noc_route_t          route;
    tracker_stats_struct core;
  } beehive_noc_hdr_flit;

  typedef struct packed {
    logic [IP_ADDR_W-1:0] src_ip;
    logic [IP_ADDR_W-1:0] dst_ip;
    logic [TOT_LEN_W-1:0] data_payload_len;
  } ip_tx_metadata_flit;

  localparam int HDR_FLIT_W = $bits(beehive_noc_hdr_flit);
  localparam int META_FLIT_W = $bits(ip_tx_metadata_flit);
endpackage

module udp_tx_noc_out
  import udp_tx_noc_out_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int SRC_X = 0,
  parameter int SRC_Y = 0,
  parameter int DST_X = 1,
  parameter int DST_Y = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_udp_tx_meta_val,
  input  logic [IP_ADDR_W-1:0]      src_udp_tx_src_ip,
  input  logic [IP_ADDR_W-1:0]      src_udp_tx_dst_ip,
  input  logic [TOT_LEN_W-1:0]      src_udp_tx_udp_len,
  input  tracker_stats_struct       src_udp_tx_timestamp,
  output logic                      udp_tx_src_meta_rdy,
  input  logic                      src_udp_tx_data_val,
  input  logic [DATA_W-1:0]         src_udp_tx_data,
  input  logic                      src_udp_tx_last,
  input  logic [MAC_PADBYTES_W-1:0] src_udp_tx_padbytes,
  output logic                      udp_tx_src_data_rdy,
  output logic                      udp_tx_out_noc0_vrtoc_val,
  output logic [DATA_W-1:0]         udp_tx_out_noc0_vrtoc_data,
  input  logic                      noc0_vrtoc_udp_tx_out_rdy,
  output logic                      udp_tx_out_len_err
);
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int BYTE_SHIFT = $clog2(DATA_BYTES);
  localparam int ML = MSG_LENGTH_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    META,
    DATA
  } state_e;

  state_e state;
  state_e state_next;

  logic [IP_ADDR_W-1:0] src_ip_r;
  logic [IP_ADDR_W-1:0] dst_ip_r;
  logic [TOT_LEN_W-1:0] udp_len_r;
  tracker_stats_struct  ts_r;
  logic [ML-1:0]        data_flits_r;
  logic [ML-1:0]        flits_rem;
  logic                 len_err_r;

  logic [ML-1:0]     len_ext;
  logic [ML-1:0]     data_flits_calc;
  logic              meta_hs;
  logic              noc_hs;
  logic              last_flit;
  logic [DATA_W-1:0] hdr_flit;
  logic [DATA_W-1:0] meta_flit;
  logic [DATA_W-1:0] data_out;

  beehive_noc_hdr_flit hdr;
  ip_tx_metadata_flit  meta;

  assign len_ext = ML'(src_udp_tx_udp_len);
  assign data_flits_calc =
    (len_ext + ML'(DATA_BYTES - 1)) >> BYTE_SHIFT;

  assign meta_hs = src_udp_tx_meta_val && udp_tx_src_meta_rdy;
  assign noc_hs = udp_tx_out_noc0_vrtoc_val
               && noc0_vrtoc_udp_tx_out_rdy;
  assign last_flit = flits_rem == ML'(1);
  assign udp_tx_out_len_err = len_err_r;

  always_comb begin
    hdr = '0;
    hdr.route.dst_x = XY_W'(DST_X);
    hdr.route.dst_y = XY_W'(DST_Y);
    hdr.route.src_x = XY_W'(SRC_X);
    hdr.route.src_y = XY_W'(SRC_Y);
    hdr.route.msg_len = data_flits_r + ML'(1);
    hdr.route.msg_type = IP_TX_MSG_TYPE;
    hdr.core = ts_r;
    hdr_flit = '0;
    hdr_flit[DATA_W-1 -: HDR_FLIT_W] = hdr;
  end

  always_comb begin
    meta.src_ip = src_ip_r;
    meta.dst_ip = dst_ip_r;
    meta.data_payload_len = udp_len_r;
    meta_flit = '0;
    meta_flit[DATA_W-1 -: META_FLIT_W] = meta;
  end

`ifdef UDP_TX_NOC_OUT_ZERO_PAD_EN
  logic [DATA_W-1:0] pad_mask;
  assign pad_mask =
    {DATA_W{1'b1}} << {src_udp_tx_padbytes, 3'b000};
  assign data_out = last_flit
    ? (src_udp_tx_data & pad_mask)
    : src_udp_tx_data;
`else
  logic unused_pad;
  assign unused_pad = ^src_udp_tx_padbytes;
  assign data_out = src_udp_tx_data;
`endif

  always_comb begin
    state_next = state;
    udp_tx_src_meta_rdy = 1'b0;
    udp_tx_src_data_rdy = 1'b0;
    udp_tx_out_noc0_vrtoc_val = 1'b0;
    udp_tx_out_noc0_vrtoc_data = '0;
    unique case (state)
      IDLE: begin
        udp_tx_src_meta_rdy = 1'b1;
        if (src_udp_tx_meta_val) state_next = HDR;
      end
      HDR: begin
        udp_tx_out_noc0_vrtoc_val = 1'b1;
        udp_tx_out_noc0_vrtoc_data = hdr_flit;
        if (noc0_vrtoc_udp_tx_out_rdy) state_next = META;
      end
      META: begin
        udp_tx_out_noc0_vrtoc_val = 1'b1;
        udp_tx_out_noc0_vrtoc_data = meta_flit;
        if (noc0_vrtoc_udp_tx_out_rdy) begin
          state_next = (data_flits_r == '0) ? IDLE : DATA;
        end
      end
      DATA: begin
        udp_tx_out_noc0_vrtoc_val = src_udp_tx_data_val;
        udp_tx_out_noc0_vrtoc_data = data_out;
        udp_tx_src_data_rdy = noc0_vrtoc_udp_tx_out_rdy;
        if (src_udp_tx_data_val && noc0_vrtoc_udp_tx_out_rdy
            && last_flit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Handshakes stay quiet while reset is held.
    if (rst) begin
      udp_tx_src_meta_rdy = 1'b0;
      udp_tx_src_data_rdy = 1'b0;
      udp_tx_out_noc0_vrtoc_val = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src_ip_r <= '0;
      dst_ip_r <= '0;
      udp_len_r <= '0;
      ts_r <= '0;
      data_flits_r <= '0;
      flits_rem <= '0;
      len_err_r <= 1'b0;
    end else begin
      state <= state_next;
      if (meta_hs) begin
        src_ip_r <= src_udp_tx_src_ip;
        dst_ip_r <= src_udp_tx_dst_ip;
        udp_len_r <= src_udp_tx_udp_len;
        ts_r <= src_udp_tx_timestamp;
        data_flits_r <= data_flits_calc;
      end
      if (state == META && noc_hs) begin
        flits_rem <= data_flits_r;
      end else if (state == DATA && noc_hs) begin
        flits_rem <= flits_rem - ML'(1);
      end
      // Framing follows the count; src_last only feeds the error flag.
      if (state == DATA && noc_hs
          && (src_udp_tx_last != last_flit)) begin
        len_err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_udp_tx_noc_out.sv
// Directed bench for udp_tx_noc_out: framing, stalls, length errors,
// mid-packet reset and last-flit padding.
module tb_udp_tx_noc_out;
  import udp_tx_noc_out_pkg::*;

  localparam int DATA_W = 512;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      meta_val = 1'b0;
  logic [IP_ADDR_W-1:0]      src_ip = '0;
  logic [IP_ADDR_W-1:0]      dst_ip = '0;
  logic [TOT_LEN_W-1:0]      udp_len = '0;
  tracker_stats_struct       ts = '0;
  logic                      meta_rdy;
  logic                      data_val = 1'b0;
  logic [DATA_W-1:0]         data = '0;
  logic                      last = 1'b0;
  logic [MAC_PADBYTES_W-1:0] padbytes = '0;
  logic                      data_rdy;
  logic                      noc_val;
  logic [DATA_W-1:0]         noc_data;
  logic                      noc_rdy = 1'b1;
  logic                      len_err;

  udp_tx_noc_out dut (
    .clk                        (clk),
    .rst                        (rst),
    .src_udp_tx_meta_val        (meta_val),
    .src_udp_tx_src_ip          (src_ip),
    .src_udp_tx_dst_ip          (dst_ip),
    .src_udp_tx_udp_len         (udp_len),
    .src_udp_tx_timestamp       (ts),
    .udp_tx_src_meta_rdy        (meta_rdy),
    .src_udp_tx_data_val        (data_val),
    .src_udp_tx_data            (data),
    .src_udp_tx_last            (last),
    .src_udp_tx_padbytes        (padbytes),
    .udp_tx_src_data_rdy        (data_rdy),
    .udp_tx_out_noc0_vrtoc_val  (noc_val),
    .udp_tx_out_noc0_vrtoc_data (noc_data),
    .noc0_vrtoc_udp_tx_out_rdy  (noc_rdy),
    .udp_tx_out_len_err         (len_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] beats [4];
  logic [DATA_W-1:0] exp_beats [4];
  logic [DATA_W-1:0] flits [$];
  bit rdy_seen;
  int gap;
  bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag,
                       input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int len, input int n);
    for (int k = 0; k < 4; k++) begin
      beats[k] = (k < n) ? {16{32'(32'hC0DE_0000 + len * 4 + k)}} : '0;
      exp_beats[k] = beats[k];
    end
  endtask

  task automatic run_pkt(input int len, input int nbeats,
                         input int last_at, input int pad,
                         input bit stall);
    int b = 0;
    int c_meta = -1;
    int c_idle = -1;
    bit meta_done = 1'b0;
    bit held = 1'b0;
    logic [DATA_W-1:0] held_flit = '0;
    flits.delete();
    rdy_seen = 1'b0;
    meta_val = 1'b1;
    src_ip = 32'h0A00_0001;
    dst_ip = 32'(32'h0A00_0100 + len);
    udp_len = 16'(len);
    ts.packet_id = 16'(16'h1200 + len);
    ts.timestamp = 64'(64'hDEAD_BEEF_0000_0000 + len);
    padbytes = 6'(pad);
    for (int cyc = 0; cyc < 100; cyc++) begin
      data_val = b < nbeats;
      data = (b < nbeats) ? beats[b] : '0;
      last = (b == last_at);
      noc_rdy = stall ? rdy_pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (held) begin
        check("stall_val", noc_val, 1);
        check("stall_data", noc_data, held_flit);
      end
      held = noc_val && !noc_rdy;
      held_flit = noc_data;
      if (data_rdy) rdy_seen = 1'b1;
      if (noc_val && noc_rdy) flits.push_back(noc_data);
      if (data_val && data_rdy) b++;
      if (meta_val && meta_rdy) begin
        meta_done = 1'b1;
        c_meta = cyc;
      end else if (meta_done && meta_rdy && c_idle < 0) begin
        c_idle = cyc;
      end
      @(posedge clk);
      #1;
      if (meta_done) meta_val = 1'b0;
      if (c_idle >= 0 && cyc > c_idle + 3) break;
    end
    meta_val = 1'b0;
    data_val = 1'b0;
    last = 1'b0;
    noc_rdy = 1'b1;
    check("idle_reached", c_idle >= 0, 1);
    gap = c_idle - c_meta;
  endtask

  task automatic check_pkt(input int len, input int msg_len,
                           input int ndata);
    beehive_noc_hdr_flit h;
    ip_tx_metadata_flit m;
    logic [DATA_W-1:0] f;
    check("flit_count", flits.size(), ndata + 2);
    if (flits.size() < 2) return;
    f = flits[0];
    h = f[DATA_W-1 -: HDR_FLIT_W];
    check("hdr_dst_x", h.route.dst_x, 1);
    check("hdr_dst_y", h.route.dst_y, 0);
    check("hdr_src_xy", {h.route.src_x, h.route.src_y}, 0);
    check("hdr_msg_len", h.route.msg_len, msg_len);
    check("hdr_msg_type", h.route.msg_type, 3);
    check("hdr_pkt_id", h.core.packet_id, 16'h1200 + len);
    check("hdr_ts", h.core.timestamp, 64'hDEAD_BEEF_0000_0000 + len);
    check("hdr_rest", f[DATA_W-HDR_FLIT_W-1:0], 0);
    f = flits[1];
    m = f[DATA_W-1 -: META_FLIT_W];
    check("meta_src_ip", m.src_ip, 32'h0A00_0001);
    check("meta_dst_ip", m.dst_ip, 32'h0A00_0100 + len);
    check("meta_len", m.data_payload_len, len);
    check("meta_rest", f[DATA_W-META_FLIT_W-1:0], 0);
    for (int k = 0; k < ndata && k + 2 < flits.size(); k++) begin
      check($sformatf("data%0d", k), flits[k + 2], exp_beats[k]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_meta_rdy", meta_rdy, 0);
    check("rst_noc_val", noc_val, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_val", noc_val, 0);
    check("post_rst_meta_rdy", meta_rdy, 1);
    check("post_rst_data_rdy", data_rdy, 0);
    check("post_rst_len_err", len_err, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] mask;
    repeat (2) @(posedge clk);
    do_reset();

    // len=100: 2 data flits, msg_len 3, 5 cycles from meta to idle
    fill(100, 2);
    run_pkt(100, 2, 1, 28, 1'b0);
    check_pkt(100, 3, 2);
    check("t1_gap", gap, 5);
    check("t1_len_err", len_err, 0);

    // len=64: exactly one beat
    fill(64, 1);
    run_pkt(64, 1, 0, 0, 1'b0);
    check_pkt(64, 2, 1);
    check("t2_len_err", len_err, 0);

    // len=0: header + metadata only
    fill(0, 0);
    run_pkt(0, 0, -1, 0, 1'b0);
    check_pkt(0, 1, 0);
    check("t3_data_rdy", rdy_seen, 0);
    check("t3_gap", gap, 3);

    // router stalls 1,0,0,1 across HDR and DATA
    fill(128, 2);
    run_pkt(128, 2, 1, 0, 1'b1);
    check_pkt(128, 3, 2);
    check("t4_len_err", len_err, 0);

    // early last: flagged, framing unchanged
    fill(128, 2);
    run_pkt(128, 2, 0, 0, 1'b0);
    check_pkt(128, 3, 2);
    check("t5_len_err", len_err, 1);
    do_reset();

    // last missing on the final beat
    fill(64, 1);
    run_pkt(64, 1, -1, 0, 1'b0);
    check_pkt(64, 2, 1);
    check("t6_len_err", len_err, 1);
    do_reset();

    // reset while the header is stalled
    meta_val = 1'b1;
    udp_len = 16'd100;
    noc_rdy = 1'b0;
    @(negedge clk);
    check("t7_meta_rdy", meta_rdy, 1);
    @(posedge clk);
    #1 meta_val = 1'b0;
    @(negedge clk);
    check("t7_hdr_val", noc_val, 1);
    do_reset();
    noc_rdy = 1'b1;

    // len=70 with 58 pad bytes on the last beat
    fill(70, 2);
    mask = '1;
    mask = mask << 464;
`ifdef UDP_TX_NOC_OUT_ZERO_PAD_EN
    exp_beats[1] = beats[1] & mask;
`endif
    run_pkt(70, 2, 1, 58, 1'b0);
    check_pkt(70, 3, 2);
    check("t8_len_err", len_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
